// File: rtl/aes_host_cfg_master.sv
// AHB-Lite initiator that programs one AES accelerator job through its slave
// register window, starts it, and polls the status register until the job
// reports done or error. All bus and status outputs are registered.
module aes_host_cfg_master #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int unsigned POLL_GAP  = 4
) (
    input  logic         hclk,
    input  logic         hrst,
    input  logic         go,
    input  logic [127:0] key_in,
    input  logic [31:0]  src_addr,
    input  logic [31:0]  dst_addr,
    input  logic [31:0]  size_in,
    output logic [31:0]  haddr,
    output logic [1:0]   htrans,
    output logic         hwrite,
    output logic [31:0]  hwdata,
    input  logic [31:0]  hrdata,
    input  logic         hready,
    input  logic         hresp,
    output logic         busy,
    output logic         done,
    output logic         err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_DATA,
        S_GAP,
        S_FIN,
        S_FAIL
    } state_t;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [3:0] IDX_STATUS    = 4'd8;
    localparam logic [7:0] GAP_LAST      = 8'(POLL_GAP - 1);

    state_t       state_q, state_d;
    logic [3:0]   idx_q, idx_d;
    logic [7:0]   gap_q, gap_d;

    logic [127:0] key_q;
    logic [31:0]  src_q, dst_q, size_q;

    logic [31:0]  haddr_d, hwdata_d;
    logic [1:0]   htrans_d;
    logic         hwrite_d, busy_d, done_d, err_d;

    // Only the two status bits of a read are meaningful.
    logic         unused_hrdata;
    assign unused_hrdata = ^hrdata[31:2];

    // Register-map write payload for sequence index i (index 7 is the start command).
    function automatic logic [31:0] reg_word(input logic [3:0]   i,
                                             input logic [127:0] k,
                                             input logic [31:0]  s,
                                             input logic [31:0]  d,
                                             input logic [31:0]  z);
        logic [31:0] w;
        case (i)
            4'd0:    w = s;
            4'd1:    w = d;
            4'd2:    w = k[127:96];
            4'd3:    w = k[95:64];
            4'd4:    w = k[63:32];
            4'd5:    w = k[31:0];
            4'd6:    w = z;
            default: w = 32'h0000_0001;
        endcase
        return w;
    endfunction

    // Job parameters are frozen on an accepted go so input changes mid-job are harmless.
    always_ff @(posedge hclk) begin
        if (state_q == S_IDLE && go) begin
            key_q  <= key_in;
            src_q  <= src_addr;
            dst_q  <= dst_addr;
            size_q <= size_in;
        end
    end

    // Control state and registered outputs.
    always_ff @(posedge hclk) begin
        if (hrst) begin
            state_q <= S_IDLE;
            idx_q   <= 4'd0;
            gap_q   <= 8'd0;
            haddr   <= 32'h0;
            htrans  <= HTRANS_IDLE;
            hwrite  <= 1'b0;
            hwdata  <= 32'h0;
            busy    <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            gap_q   <= gap_d;
            haddr   <= haddr_d;
            htrans  <= htrans_d;
            hwrite  <= hwrite_d;
            hwdata  <= hwdata_d;
            busy    <= busy_d;
            done    <= done_d;
            err     <= err_d;
        end
    end

    // Next-state: write sequence, status poll, and gap countdown between polls.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        gap_d   = gap_q;
        case (state_q)
            S_IDLE: begin
                if (go) begin
                    state_d = S_ADDR;
                    idx_d   = 4'd0;
                end
            end
            S_ADDR: state_d = S_DATA;
            S_DATA: begin
                if (hready) begin
                    if (hresp) begin
                        state_d = S_FAIL;
                    end else if (idx_q != IDX_STATUS) begin
                        idx_d   = idx_q + 4'd1;
                        state_d = S_ADDR;
                    end else begin
                        case (hrdata[1:0])
                            2'b10:   state_d = S_FIN;
                            2'b11:   state_d = S_FAIL;
                            default: begin
                                state_d = S_GAP;
                                gap_d   = 8'd0;
                            end
                        endcase
                    end
                end
            end
            S_GAP: begin
                if (gap_q == GAP_LAST) begin
                    state_d = S_ADDR;
                    gap_d   = 8'd0;
                end else begin
                    gap_d = gap_q + 8'd1;
                end
            end
            S_FIN, S_FAIL: begin
                state_d = S_IDLE;
                idx_d   = 4'd0;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Output decode from the upcoming state so every output leaves a flop.
    always_comb begin
        haddr_d  = 32'h0;
        htrans_d = HTRANS_IDLE;
        hwrite_d = 1'b0;
        hwdata_d = 32'h0;
        busy_d   = (state_d != S_IDLE);
        done_d   = (state_d == S_FIN);
        err_d    = (state_d == S_FAIL);
        case (state_d)
            S_ADDR: begin
                haddr_d  = BASE_ADDR + {26'd0, idx_d, 2'b00};
                htrans_d = HTRANS_NONSEQ;
                hwrite_d = (idx_d < IDX_STATUS);
            end
            S_DATA: begin
                haddr_d  = BASE_ADDR + {26'd0, idx_d, 2'b00};
                hwrite_d = (idx_d < IDX_STATUS);
                if (idx_d < IDX_STATUS)
                    hwdata_d = reg_word(idx_d, key_q, src_q, dst_q, size_q);
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_aes_host_cfg_master.sv
// Bench for aes_host_cfg_master: an AHB slave model with programmable wait
// states, error responses and status answers; expected transfers and job
// endings are queued by the stimulus and consumed by an independent monitor.
module tb_aes_host_cfg_master;

    localparam logic [31:0] BASE = 32'h0000_0000;
    localparam int          GAP  = 4;

    logic         hclk, hrst, go;
    logic [127:0] key_in;
    logic [31:0]  src_addr, dst_addr, size_in;
    logic [31:0]  haddr, hwdata, hrdata;
    logic [1:0]   htrans;
    logic         hwrite, hready, hresp, busy, done, err;

    aes_host_cfg_master #(.BASE_ADDR(BASE), .POLL_GAP(GAP)) dut (
        .hclk(hclk), .hrst(hrst), .go(go), .key_in(key_in),
        .src_addr(src_addr), .dst_addr(dst_addr), .size_in(size_in),
        .haddr(haddr), .htrans(htrans), .hwrite(hwrite), .hwdata(hwdata),
        .hrdata(hrdata), .hready(hready), .hresp(hresp),
        .busy(busy), .done(done), .err(err)
    );

    initial hclk = 1'b0;
    always #5 hclk = ~hclk;

    int cyc = 0;
    always @(posedge hclk) cyc <= cyc + 1;

    int checks   = 0;
    int failures = 0;

    // Expected bus transfers, in order
    logic [31:0] exp_addr_q[$];
    bit          exp_wr_q[$];
    logic [31:0] exp_data_q[$];
    // Expected job endings: kind 0 = done, 1 = err; cycle number at which it shows
    bit          ev_kind_q[$];
    int          ev_cyc_q[$];

    // Slave behaviour for the current job
    int          sl_wait[32];
    int          sl_err;
    int          sl_x;
    logic [1:0]  st_q[$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", nm, act, expv, cyc);
        end
    endtask

    // AHB slave: data phase follows each NONSEQ; waits assert hresp with hready low
    initial begin : slave
        bit a_ph, a_wr, rst_s, in_dp, rd;
        int left, cur;
        logic [1:0] st;
        logic [31:0] tmp;
        hready = 1'b1; hresp = 1'b0; hrdata = 32'h0;
        in_dp = 0; left = 0; cur = 0; rd = 0; st = 2'b00;
        forever begin
            @(negedge hclk);
            a_ph  = (htrans == 2'b10) && !hrst;
            a_wr  = hwrite;
            rst_s = hrst;
            if (in_dp && hready) in_dp = 0;
            @(posedge hclk);
            #1;
            tmp = $urandom;
            if (rst_s) in_dp = 0;
            if (a_ph) begin
                in_dp = 1;
                cur   = sl_x;
                sl_x++;
                left  = (cur < 32) ? sl_wait[cur] : 0;
                rd    = !a_wr;
                st    = 2'b01;
                if (rd && st_q.size() != 0) st = st_q.pop_front();
            end
            if (in_dp && left > 0) begin
                hready = 1'b0;
                hresp  = 1'b1;
                hrdata = {tmp[31:2], 2'b11};
                left--;
            end else if (in_dp) begin
                hready = 1'b1;
                hresp  = (cur == sl_err);
                hrdata = {tmp[31:2], rd ? st : 2'b00};
            end else begin
                hready = 1'b1;
                hresp  = 1'b0;
                hrdata = tmp;
            end
        end
    end

    // Monitor: checks each address/data phase and each job ending against the queues
    initial begin : monitor
        bit in_dp, cur_wr, post_ev, k;
        logic [31:0] cur_data, a, d;
        bit w;
        int c;
        in_dp = 0; cur_wr = 0; post_ev = 0; cur_data = 0;
        forever begin
            @(negedge hclk);
            if (post_ev) begin
                chk("busy_after_end", busy, 0);
                post_ev = 0;
            end
            if (in_dp) begin
                if (cur_wr) chk("hwdata", hwdata, cur_data);
                if (hready || hrst) in_dp = 0;
            end
            if (htrans == 2'b10) begin
                if (exp_addr_q.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL unexpected_xfer haddr=%0h required=no_transfer (cycle %0d)", haddr, cyc);
                end else begin
                    a = exp_addr_q.pop_front();
                    w = exp_wr_q.pop_front();
                    d = exp_data_q.pop_front();
                    chk("haddr", haddr, a);
                    chk("hwrite", hwrite, w);
                    chk("busy_in_xfer", busy, 1);
                    in_dp = 1; cur_wr = w; cur_data = d;
                end
            end
            if (done || err) begin
                if (ev_kind_q.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL unexpected_end done=%0b err=%0b required=none (cycle %0d)", done, err, cyc);
                end else begin
                    k = ev_kind_q.pop_front();
                    c = ev_cyc_q.pop_front();
                    chk("end_kind_done_err", {done, err}, k ? 2'b01 : 2'b10);
                    chk("end_cycle", cyc, c);
                    post_ev = 1;
                end
            end
        end
    end

    task automatic clear_slave();
        for (int i = 0; i < 32; i++) sl_wait[i] = 0;
        sl_err = -1;
        st_q.delete();
    endtask

    task automatic scramble_inputs();
        key_in   = {$urandom, $urandom, $urandom, $urandom};
        src_addr = $urandom;
        dst_addr = $urandom;
        size_in  = $urandom;
    endtask

    // Reference model of one job: ordered register writes, then status reads until a
    // terminal status; each transfer costs 2 cycles plus its wait states, each
    // non-terminal poll adds the idle gap.
    task automatic do_job(input logic [127:0] k, input logic [31:0] s, input logic [31:0] d,
                          input logic [31:0] z, input int err_x);
        logic [31:0] words [8];
        int n_wr, n_rd, tot, off, n0, budget;
        bit kind;
        words[0] = s;          words[1] = d;
        words[2] = k[127:96];  words[3] = k[95:64];
        words[4] = k[63:32];   words[5] = k[31:0];
        words[6] = z;          words[7] = 32'h1;
        n_rd = 0;
        kind = 0;
        if (err_x >= 0) begin
            n_wr = err_x + 1;
            kind = 1;
        end else begin
            n_wr = 8;
            n_rd = st_q.size();
            for (int i = st_q.size() - 1; i >= 0; i--) begin
                if (st_q[i] == 2'b10 || st_q[i] == 2'b11) begin
                    n_rd = i + 1;
                    kind = (st_q[i] == 2'b11);
                end
            end
        end
        tot = 0;
        for (int i = 0; i < n_wr + n_rd; i++) tot += sl_wait[i];
        if (err_x >= 0) off = 2 + 2 * err_x + tot;
        else            off = 18 + tot + (n_rd - 1) * (GAP + 2);
        for (int i = 0; i < n_wr; i++) begin
            exp_addr_q.push_back(BASE + 32'(4 * i));
            exp_wr_q.push_back(1'b1);
            exp_data_q.push_back(words[i]);
        end
        for (int r = 0; r < n_rd; r++) begin
            exp_addr_q.push_back(BASE + 32'h20);
            exp_wr_q.push_back(1'b0);
            exp_data_q.push_back(32'h0);
        end
        sl_x = 0;
        sl_err = err_x;
        key_in = k; src_addr = s; dst_addr = d; size_in = z;
        go = 1'b1;
        @(posedge hclk);
        #1;
        n0 = cyc;
        go = 1'b0;
        ev_kind_q.push_back(kind);
        ev_cyc_q.push_back(n0 + off);
        scramble_inputs();
        if (err_x < 0 || err_x >= 4) begin
            repeat (3) @(posedge hclk);
            #1;
            go = 1'b1;
            @(posedge hclk);
            #1;
            go = 1'b0;
        end
        budget = 400;
        while (ev_kind_q.size() != 0 && budget > 0) begin
            @(posedge hclk);
            budget--;
        end
        chk("job_end_seen_before_timeout", ev_kind_q.size(), 0);
        ev_kind_q.delete();
        ev_cyc_q.delete();
        repeat (3) @(posedge hclk);
        #1;
        chk("all_xfers_seen", exp_addr_q.size(), 0);
        exp_addr_q.delete(); exp_wr_q.delete(); exp_data_q.delete();
        clear_slave();
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_haddr"},  haddr, 0);
        chk({tag, "_htrans"}, htrans, 0);
        chk({tag, "_hwrite"}, hwrite, 0);
        chk({tag, "_hwdata"}, hwdata, 0);
        chk({tag, "_busy"},   busy, 0);
        chk({tag, "_done"},   done, 0);
        chk({tag, "_err"},    err, 0);
    endtask

    // Job left polling forever; reset lands on the second status address phase.
    task automatic reset_mid_poll();
        logic [127:0] k;
        logic [31:0] s, d, z;
        int n0;
        k = {$urandom, $urandom, $urandom, $urandom};
        s = $urandom; d = $urandom; z = $urandom;
        for (int i = 0; i < 8; i++) begin
            exp_addr_q.push_back(BASE + 32'(4 * i));
            exp_wr_q.push_back(1'b1);
        end
        exp_data_q.push_back(s);          exp_data_q.push_back(d);
        exp_data_q.push_back(k[127:96]);  exp_data_q.push_back(k[95:64]);
        exp_data_q.push_back(k[63:32]);   exp_data_q.push_back(k[31:0]);
        exp_data_q.push_back(z);          exp_data_q.push_back(32'h1);
        for (int r = 0; r < 2; r++) begin
            exp_addr_q.push_back(BASE + 32'h20);
            exp_wr_q.push_back(1'b0);
            exp_data_q.push_back(32'h0);
        end
        sl_x = 0;
        sl_err = -1;
        key_in = k; src_addr = s; dst_addr = d; size_in = z;
        go = 1'b1;
        @(posedge hclk);
        #1;
        n0 = cyc;
        go = 1'b0;
        scramble_inputs();
        repeat (3) @(posedge hclk);
        #1;
        go = 1'b1;
        @(posedge hclk);
        #1;
        go = 1'b0;
        while (cyc < n0 + 22) begin
            @(posedge hclk);
            #1;
        end
        hrst = 1'b1;
        @(posedge hclk);
        #1;
        hrst = 1'b0;
        @(negedge hclk);
        check_reset_outputs("mid_poll_reset");
        chk("xfers_before_reset", exp_addr_q.size(), 0);
        exp_addr_q.delete(); exp_wr_q.delete(); exp_data_q.delete();
        clear_slave();
        @(posedge hclk);
        #1;
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int nb, ex;
        hrst = 1'b1;
        go = 1'b0;
        key_in = '0; src_addr = '0; dst_addr = '0; size_in = '0;
        clear_slave();
        sl_x = 0;
        repeat (3) @(posedge hclk);
        #1;
        hrst = 1'b0;
        @(negedge hclk);
        check_reset_outputs("reset");
        @(posedge hclk);
        #1;

        // Zero-wait job, first status read returns done
        st_q.push_back(2'b10);
        do_job(128'h68656c6c6f3030303030303030303030, 32'h100, 32'h200, 32'h40, -1);

        // Three wait states on the 0x0C write
        sl_wait[3] = 3;
        st_q.push_back(2'b10);
        do_job(128'h68656c6c6f3030303030303030303030, 32'h100, 32'h200, 32'h40, -1);

        // Polling: busy, busy, done
        st_q.push_back(2'b01); st_q.push_back(2'b01); st_q.push_back(2'b10);
        do_job(128'h68656c6c6f3030303030303030303030, 32'h100, 32'h200, 32'h40, -1);

        // Bus error on the 0x14 data phase
        do_job(128'h68656c6c6f3030303030303030303030, 32'h100, 32'h200, 32'h40, 5);

        // Accelerator error status
        st_q.push_back(2'b11);
        do_job(128'h0123456789abcdef0011223344556677, 32'h1000, 32'h2000, 32'h80, -1);

        // Reset during the poll, then a fresh job from offset 0x00
        reset_mid_poll();
        st_q.push_back(2'b10);
        do_job({$urandom, $urandom, $urandom, $urandom}, $urandom, $urandom, $urandom, -1);

        // Randomized jobs
        for (int j = 0; j < 12; j++) begin
            for (int i = 0; i < 32; i++) sl_wait[i] = int'($urandom_range(0, 2));
            nb = int'($urandom_range(0, 3));
            for (int i = 0; i < nb; i++) st_q.push_back(2'($urandom_range(0, 1)));
            if ($urandom_range(0, 3) == 0) st_q.push_back(2'b11);
            else                           st_q.push_back(2'b10);
            if ($urandom_range(0, 3) == 0) ex = int'($urandom_range(0, 7));
            else                           ex = -1;
            do_job({$urandom, $urandom, $urandom, $urandom}, $urandom, $urandom, $urandom, ex);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
